// File: rtl/dec_pkg.sv
// Shared types and helpers for the pulse decoder.
// Holds the FSM state type, the one-hot helper and counter sizing.
package dec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } dec_state_t;

  localparam int MAX_W = 64;

  localparam int DEF_N = 2;
  localparam int DEF_PULSE_LEN = 4;

  function automatic int cw_of(input int pulse_len);
    return (pulse_len > 1) ? $clog2(pulse_len) : 1;
  endfunction

  localparam int DEF_CW = cw_of(DEF_PULSE_LEN);

  // Callers truncate the result to their own W = 2**N.
  function automatic logic [MAX_W-1:0] onehot(
    input int unsigned code
  );
    logic [MAX_W-1:0] one;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational N -> 2**N one-hot decoder.
// Output is forced to zero when not enabled.
module dec_onehot
  import dec_pkg::*;
#(
  parameter  int N = 2,
  localparam int W = 2**N
) (
  input  logic [N-1:0] a,
  input  logic         en,
  output logic [W-1:0] d
);

  // Gating keeps an undriven code from reaching the output register.
  assign d = en ? W'(onehot(32'(a))) : '0;

endmodule

// File: rtl/dec_2_4_pulse.sv
// Registered binary-to-one-hot decoder with handshake.
// Drives one line of d for PULSE_LEN cycles per accepted code.
module dec_2_4_pulse
  import dec_pkg::*;
#(
  parameter  int N = DEF_N,
  parameter  int PULSE_LEN = DEF_PULSE_LEN,
  localparam int W = 2**N,
  localparam int CW = cw_of(PULSE_LEN)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [N-1:0] a,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] d,
  output logic         busy,
  output logic         done
);

  localparam logic [CW-1:0] LAST = CW'(PULSE_LEN - 1);

  dec_state_t     state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [W-1:0]   d_n;
  logic           done_n;
  logic [W-1:0]   dec;

  dec_onehot #(
    .N (N)
  ) u_dec (
    .a  (a),
    .en (in_valid),
    .d  (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      d     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      d     <= d_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    d_n     = d;
    done_n  = 1'b0;
    if (clr) begin
      state_n = IDLE;
      cnt_n   = '0;
      d_n     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state_n = PULSE;
            cnt_n   = LAST;
            d_n     = dec;
          end
        end
        PULSE: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else begin
            state_n = IDLE;
            d_n     = '0;
            done_n  = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          d_n     = '0;
        end
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == PULSE);

endmodule

// File: tb/tb_dec_2_4_pulse.sv
// Bench for dec_2_4_pulse: directed scenarios plus random traffic.
// Two instances (PULSE_LEN 4 and 1) share inputs against a timeline model.
module tb_dec_2_4_pulse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] a = 2'd0;
  logic       in_valid = 1'b0;

  logic       rdy0, busy0, done0;
  logic [3:0] d0;
  logic       rdy1, busy1, done1;
  logic [3:0] d1;

  int errs = 0;
  int checks = 0;

  int left [2];
  int code [2];
  bit done_e [2];
  int plen [2] = '{4, 1};

  always #5 clk = ~clk;

  dec_2_4_pulse #(.N(2), .PULSE_LEN(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .a        (a),
    .in_valid (in_valid),
    .in_ready (rdy0),
    .d        (d0),
    .busy     (busy0),
    .done     (done0)
  );

  dec_2_4_pulse #(.N(2), .PULSE_LEN(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .a        (a),
    .in_valid (in_valid),
    .in_ready (rdy1),
    .d        (d1),
    .busy     (busy1),
    .done     (done1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // A pulse is a count of remaining high cycles for a latched code.
  task automatic model_edge(input int k);
    bit was_last;
    was_last = (left[k] == 1);
    if (!rst_n || clr) begin
      left[k]   = 0;
      done_e[k] = 1'b0;
    end else begin
      done_e[k] = was_last;
      if (left[k] > 0) begin
        left[k]--;
      end else if (in_valid) begin
        left[k] = plen[k];
        code[k] = int'(a);
      end
    end
  endtask

  function automatic logic [31:0] exp_d(input int k);
    return (left[k] > 0) ? (32'd1 << code[k]) : 32'd0;
  endfunction

  task automatic check_all();
    chk("d4",     32'(d0),    exp_d(0));
    chk("busy4",  32'(busy0), 32'(left[0] > 0));
    chk("rdy4",   32'(rdy0),  32'(left[0] == 0));
    chk("done4",  32'(done0), 32'(done_e[0]));
    chk("d1",     32'(d1),    exp_d(1));
    chk("busy1",  32'(busy1), 32'(left[1] > 0));
    chk("rdy1",   32'(rdy1),  32'(left[1] == 0));
    chk("done1",  32'(done1), 32'(done_e[1]));
  endtask

  task automatic step(input logic rn, input logic c,
                      input logic v, input logic [1:0] aa);
    rst_n    = rn;
    clr      = c;
    in_valid = v;
    a        = aa;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  // Wait (bounded) until the long-pulse instance is ready.
  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!rdy0 && guard < 20) begin
      step(1'b1, 1'b0, 1'b0, 2'd0);
      guard++;
    end
    chk("ready_timeout", 32'(rdy0), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      left[k] = 0;
      code[k] = 0;
      done_e[k] = 1'b0;
    end
    @(negedge clk);

    // reset
    step(1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0);
    idle(1);

    // sweep all codes
    for (int c = 0; c < 4; c++) begin
      wait_ready();
      step(1'b1, 1'b0, 1'b1, 2'(c));
      idle(6);
    end

    // request held while busy is not queued
    wait_ready();
    step(1'b1, 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 2'd3);
    idle(6);

    // abort on pulse cycle 2
    wait_ready();
    step(1'b1, 1'b0, 1'b1, 2'd1);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    idle(4);

    // clr beats a simultaneous accept
    step(1'b1, 1'b1, 1'b1, 2'd3);
    idle(2);

    // reset mid-pulse
    wait_ready();
    step(1'b1, 1'b0, 1'b1, 2'd0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 2'd0);
    idle(5);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 59) != 0),
           1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 2) != 0),
           2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
